// File: rtl/imem_program_loader_if.sv
// Purpose: bundles the loader's control, byte-stream and memory-port signals.
// Latency: none (wires only).
// Backpressure: byte stream uses byte_valid/byte_ready; the CPU side is held off with cpu_stall.
//
// Ports:
//   start/base_addr/word_count   load request and its parameters (host -> loader)
//   byte_valid/byte_data/byte_ready  program byte stream, big-endian within a word
//   cpu_addr                     CPU fetch word address (PC)
//   mem_addr/mem_data/mem_we     instruction memory write/read-address port
//   cpu_stall/busy/done          status towards the CPU and the OS
interface imem_program_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 10
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [CNT_WIDTH-1:0]  word_count;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_we;
    logic                  cpu_stall;
    logic                  busy;
    logic                  done;

    // Host / byte source / CPU side.
    modport master (
        output start, base_addr, word_count, byte_valid, byte_data, cpu_addr,
        input  byte_ready, mem_addr, mem_data, mem_we, cpu_stall, busy, done
    );

    // Loader side.
    modport slave (
        input  start, base_addr, word_count, byte_valid, byte_data, cpu_addr,
        output byte_ready, mem_addr, mem_data, mem_we, cpu_stall, busy, done
    );
endinterface

// File: rtl/imem_program_loader.sv
// Purpose: loads a byte-streamed program image into instruction memory, muxing the memory port with CPU fetch.
// Latency: each word is written 1 cycle after its 4th byte; a full load takes 5*word_count+1 cycles minimum.
// Backpressure: byte_ready only in LOAD, so the source stalls during WRITE/DONE/IDLE; CPU is stalled while busy.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   bus          imem_program_loader_if.slave: start/base_addr/word_count request,
//                byte_valid/byte_data/byte_ready stream, cpu_addr in,
//                mem_addr/mem_data/mem_we to memory, cpu_stall/busy/done status
module imem_program_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_program_loader_if.slave  bus
);

    // Byte packing below assumes exactly four bytes per word.
    if (DATA_WIDTH != 32) begin : g_width_check
        $error("imem_program_loader: DATA_WIDTH must be 32");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  word_idx;
    logic [1:0]            byte_cnt;
    logic [DATA_WIDTH-1:0] word_buf;
    logic [DATA_WIDTH-1:0] mem_data_q;

    logic                  byte_acc;
    logic                  last_word;

    assign byte_acc  = (state == LOAD) && bus.byte_valid;
    assign last_word = ((word_idx + CNT_WIDTH'(1)) == count_q);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.word_count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (byte_acc && (byte_cnt == 2'd3)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = last_word ? DONE : LOAD;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: request capture, byte assembly, word indexing.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q     <= '0;
            count_q    <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            mem_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        base_q   <= bus.base_addr;
                        count_q  <= bus.word_count;
                        word_idx <= '0;
                        byte_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (byte_acc) begin
                        // First byte of a word lands in the MSB.
                        word_buf[(DATA_WIDTH - 1) - 8 * byte_cnt -: 8] <= bus.byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        // Latch the complete word separately so mem_data keeps the last
                        // written word while the next one is being assembled.
                        if (byte_cnt == 2'd3) begin
                            mem_data_q <= {word_buf[DATA_WIDTH-1:8], bus.byte_data};
                        end
                    end
                end
                WRITE: begin
                    if (!last_word) begin
                        word_idx <= word_idx + CNT_WIDTH'(1);
                        byte_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state.
    always_comb begin
        bus.byte_ready = 1'b0;
        bus.mem_we     = 1'b0;
        bus.done       = 1'b0;
        bus.busy       = 1'b0;
        bus.cpu_stall  = 1'b0;
        bus.mem_addr   = bus.cpu_addr;
        case (state)
            IDLE: begin
            end
            LOAD: begin
                bus.byte_ready = 1'b1;
                bus.busy       = 1'b1;
                bus.cpu_stall  = 1'b1;
            end
            WRITE: begin
                bus.mem_we    = 1'b1;
                bus.busy      = 1'b1;
                bus.cpu_stall = 1'b1;
                // Address arithmetic wraps naturally at the top of memory.
                bus.mem_addr  = base_q + word_idx[ADDR_WIDTH-1:0];
            end
            DONE: begin
                // Fetch address returns here so the first instruction is ready in IDLE.
                bus.done      = 1'b1;
                bus.busy      = 1'b1;
                bus.cpu_stall = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.mem_data = mem_data_q;

endmodule
